// File: rtl/sprite_rom_fetch_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : sprite_rom_fetch_sched_if
// Description : Command, ROM, line-buffer and host-port bundle of the sprite
//               ROM fetch scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface sprite_rom_fetch_sched_if #(
    parameter int LB_AW = 10
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_sprite;
    logic [3:0]       cmd_row;
    logic [LB_AW-1:0] cmd_x;

    logic [11:0]      rom_address;
    logic             rom_chipselect;
    logic             rom_clken;
    logic [7:0]       rom_readdata;

    logic             lb_we;
    logic [LB_AW-1:0] lb_addr;
    logic [7:0]       lb_data;

    logic             host_req;
    logic [11:0]      host_addr;
    logic             host_gnt;
    logic             host_rvalid;
    logic [7:0]       host_rdata;

    logic             busy;
    logic             done;

    // Environment side: sprite engine, host port and ROM data return.
    modport master (
        output cmd_valid, cmd_sprite, cmd_row, cmd_x, rom_readdata, host_req, host_addr,
        input  cmd_ready, rom_address, rom_chipselect, rom_clken, lb_we, lb_addr, lb_data,
               host_gnt, host_rvalid, host_rdata, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_sprite, cmd_row, cmd_x, rom_readdata, host_req, host_addr,
        output cmd_ready, rom_address, rom_chipselect, rom_clken, lb_we, lb_addr, lb_data,
               host_gnt, host_rvalid, host_rdata, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/sprite_rom_fetch_sched.sv
`default_nettype none
// ============================================================================
// Module      : sprite_rom_fetch_sched
// Description : Owns the sprite pattern ROM; streams 16-pixel row fetches into
//               the line buffer and interleaves single-byte host reads fairly.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_rom_fetch_sched #(
    parameter int         SPR_DIM     = 16,
    parameter int         LINE_PIXELS = 640,
    parameter int         LB_AW       = 10,
    parameter logic [7:0] TRANSPARENT = 8'h00
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    sprite_rom_fetch_sched_if.slave bus
);
    localparam int                 c_COL_W       = $clog2(SPR_DIM);
    localparam logic [c_COL_W-1:0] c_LAST_COL    = c_COL_W'(SPR_DIM - 1);
    localparam logic [LB_AW:0]     c_LINE_PIXELS = (LB_AW + 1)'(LINE_PIXELS);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_HOST  = 2'd3;

    logic [1:0]         r_state;
    logic               r_last_cmd;
    logic [11:0]        r_rom_address;
    logic               r_rom_cs;
    logic               r_rom_clken;
    logic [LB_AW-1:0]   r_x;
    logic               r_pix_valid;
    logic [c_COL_W-1:0] r_pix_col;
    logic               r_host_pend;
    logic               r_lb_we;
    logic [LB_AW-1:0]   r_lb_addr;
    logic [7:0]         r_lb_data;
    logic               r_done;
    logic               r_host_gnt;
    logic               r_host_rvalid;
    logic [7:0]         r_host_rdata;

    logic               w_idle;
    logic               w_cmd_ready;
    logic               w_cmd_go;
    logic [c_COL_W-1:0] w_cur_col;
    logic [LB_AW:0]     w_lb_sum;
    logic               w_lb_we;

    // Host wins a tie only when the previous grant went to a command.
    assign w_idle      = (r_state == c_ST_IDLE);
    assign w_cmd_ready = w_idle & ~(bus.host_req & r_last_cmd);
    assign w_cmd_go    = bus.cmd_valid & w_cmd_ready;
    assign w_cur_col   = r_rom_address[c_COL_W-1:0];

    // One extra bit so pixels past the line end are dropped instead of wrapping.
    assign w_lb_sum = {1'b0, r_x} + (LB_AW + 1)'(r_pix_col);
    assign w_lb_we  = (bus.rom_readdata != TRANSPARENT) && (w_lb_sum < c_LINE_PIXELS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_ST_IDLE;
            r_last_cmd    <= 1'b0;
            r_rom_address <= '0;
            r_rom_cs      <= 1'b0;
            r_rom_clken   <= 1'b0;
            r_x           <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_col     <= '0;
            r_host_pend   <= 1'b0;
            r_lb_we       <= 1'b0;
            r_lb_addr     <= '0;
            r_lb_data     <= '0;
            r_done        <= 1'b0;
            r_host_gnt    <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= '0;
        end else begin
            r_rom_clken   <= 1'b1;
            r_rom_cs      <= 1'b0;
            r_host_gnt    <= 1'b0;
            r_pix_valid   <= 1'b0;
            r_host_pend   <= 1'b0;
            r_lb_we       <= 1'b0;
            r_done        <= 1'b0;
            r_host_rvalid <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_cmd_go) begin
                        r_state       <= c_ST_FETCH;
                        r_rom_address <= {bus.cmd_sprite, bus.cmd_row, {c_COL_W{1'b0}}};
                        r_rom_cs      <= 1'b1;
                        r_x           <= bus.cmd_x;
                        r_last_cmd    <= 1'b1;
                    end else if (bus.host_req) begin
                        r_state       <= c_ST_HOST;
                        r_rom_address <= bus.host_addr;
                        r_rom_cs      <= 1'b1;
                        r_host_gnt    <= 1'b1;
                        r_last_cmd    <= 1'b0;
                    end
                end
                c_ST_FETCH: begin
                    r_pix_valid <= 1'b1;
                    r_pix_col   <= w_cur_col;
                    if (w_cur_col == c_LAST_COL) begin
                        r_state <= c_ST_DRAIN;
                    end else begin
                        r_rom_address[c_COL_W-1:0] <= w_cur_col + 1'b1;
                        r_rom_cs                   <= 1'b1;
                    end
                end
                c_ST_DRAIN: begin
                    // Leave once the final column's write slot has been presented.
                    if (r_done) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_HOST: begin
                    r_host_pend <= 1'b1;
                    r_state     <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase

            if (r_pix_valid) begin
                r_lb_we   <= w_lb_we;
                r_lb_addr <= w_lb_sum[LB_AW-1:0];
                r_lb_data <= bus.rom_readdata;
                r_done    <= (r_pix_col == c_LAST_COL);
            end

            if (r_host_pend) begin
                r_host_rvalid <= 1'b1;
                r_host_rdata  <= bus.rom_readdata;
            end
        end
    end

    assign bus.cmd_ready      = w_cmd_ready;
    assign bus.rom_address    = r_rom_address;
    assign bus.rom_chipselect = r_rom_cs;
    assign bus.rom_clken      = r_rom_clken;
    assign bus.lb_we          = r_lb_we;
    assign bus.lb_addr        = r_lb_addr;
    assign bus.lb_data        = r_lb_data;
    assign bus.host_gnt       = r_host_gnt;
    assign bus.host_rvalid    = r_host_rvalid;
    assign bus.host_rdata     = r_host_rdata;
    assign bus.busy           = ~w_idle;
    assign bus.done           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_fetch_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sprite_rom_fetch_sched
// Description : Directed self-checking bench for sprite_rom_fetch_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_rom_fetch_sched;
    localparam int LB_AW = 10;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sprite_rom_fetch_sched_if #(.LB_AW(LB_AW)) bus();

    sprite_rom_fetch_sched #(
        .SPR_DIM     (16),
        .LINE_PIXELS (640),
        .LB_AW       (LB_AW),
        .TRANSPARENT (8'h00)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ROM model: one-cycle read latency.
    logic [7:0] rom [4096];
    logic [7:0] rom_q = 8'h00;
    always @(posedge clk) if (bus.rom_chipselect) rom_q <= rom[bus.rom_address];
    assign bus.rom_readdata = rom_q;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [7:0] rom_val(input int a);
        return (8'(a) + 8'h11) | 8'h01;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_rom_addr"}, bus.rom_address, 0);
        check({tag, "_rom_cs"}, bus.rom_chipselect, 0);
        check({tag, "_rom_clken"}, bus.rom_clken, 0);
        check({tag, "_lb_we"}, bus.lb_we, 0);
        check({tag, "_lb_addr"}, bus.lb_addr, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_host_gnt"}, bus.host_gnt, 0);
        check({tag, "_host_rvalid"}, bus.host_rvalid, 0);
    endtask

    // Issues one command and checks cycles T+1..T+19; abort_k>0 asserts reset at T+abort_k.
    task automatic run_fetch(input logic [3:0] s, input logic [3:0] r, input logic [9:0] x,
                             input logic [15:0] mask, input int abort_k);
        logic exp_we;
        @(negedge clk);
        check("cmd_ready", bus.cmd_ready, 1);
        bus.cmd_sprite = s;
        bus.cmd_row    = r;
        bus.cmd_x      = x;
        bus.cmd_valid  = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            if (k == abort_k) begin
                reset_n = 1'b0;
                #1;
                check_reset_outs("abort");
                return;
            end
            check("rom_cs", bus.rom_chipselect, (k <= 16));
            if (k <= 16) check("rom_addr", bus.rom_address, {s, r, 4'(k - 1)});
            exp_we = (k >= 3 && k <= 18) ? mask[k - 3] : 1'b0;
            check("lb_we", bus.lb_we, exp_we);
            if (exp_we) begin
                check("lb_addr", bus.lb_addr, x + 10'(k - 3));
                check("lb_data", bus.lb_data, rom[{s, r, 4'(k - 3)}]);
            end
            check("done", bus.done, (k == 18));
            check("busy", bus.busy, (k <= 18));
            if (k < 19) @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, ngr, gnt_cyc, n_rv;
        logic pending;
        logic [1:0] exp_seq [4];

        bus.cmd_valid  = 1'b0;
        bus.cmd_sprite = '0;
        bus.cmd_row    = '0;
        bus.cmd_x      = '0;
        bus.host_req   = 1'b0;
        bus.host_addr  = '0;
        for (int i = 0; i < 4096; i++) rom[i] = rom_val(i);

        repeat (3) @(negedge clk);
        check_reset_outs("rst");
        reset_n = 1'b1;
        @(negedge clk);
        check("clken_after_rst", bus.rom_clken, 1);

        // Plain fetch, all pixels opaque.
        run_fetch(4'd3, 4'd5, 10'd100, 16'hFFFF, 0);

        // Transparent pixels at columns 2 and 7 are skipped.
        rom[12'h352] = 8'h00;
        rom[12'h357] = 8'h00;
        run_fetch(4'd3, 4'd5, 10'd100, 16'hFF7B, 0);
        rom[12'h352] = rom_val(12'h352);
        rom[12'h357] = rom_val(12'h357);

        // Right-edge clip: only 630..639 written.
        run_fetch(4'd7, 4'd9, 10'd630, 16'h03FF, 0);

        // Host-only read of 0xABC.
        bus.host_addr = 12'hABC;
        bus.host_req  = 1'b1;
        @(negedge clk);
        check("h_gnt", bus.host_gnt, 1);
        check("h_busy", bus.busy, 1);
        check("h_rom_addr", bus.rom_address, 12'hABC);
        check("h_rom_cs", bus.rom_chipselect, 1);
        check("h_rvalid_early", bus.host_rvalid, 0);
        bus.host_req = 1'b0;
        @(negedge clk);
        check("h_gnt_pulse", bus.host_gnt, 0);
        check("h_busy_1cyc", bus.busy, 0);
        check("h_rvalid_h1", bus.host_rvalid, 0);
        @(negedge clk);
        check("h_rvalid", bus.host_rvalid, 1);
        check("h_rdata", bus.host_rdata, 8'hCD);
        @(negedge clk);
        check("h_rvalid_pulse", bus.host_rvalid, 0);

        // Both sides requesting continuously: grants alternate (0 = CMD, 1 = HOST).
        exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd0; exp_seq[3] = 2'd1;
        bus.cmd_sprite = 4'd1;
        bus.cmd_row    = 4'd2;
        bus.cmd_x      = 10'd0;
        bus.cmd_valid  = 1'b1;
        bus.host_addr  = 12'h123;
        bus.host_req   = 1'b1;
        cyc = 0; ngr = 0; gnt_cyc = 0; n_rv = 0; pending = 1'b0;
        while ((ngr < 4 || pending) && cyc < 200) begin
            if (bus.host_rvalid) begin
                check("alt_rv_latency", cyc - gnt_cyc, 2);
                check("alt_rdata", bus.host_rdata, 8'h35);
                pending = 1'b0;
                n_rv++;
            end
            if (bus.host_gnt && ngr < 4) begin
                check("alt_order", 2'd1, exp_seq[ngr]);
                ngr++;
                gnt_cyc = cyc;
                pending = 1'b1;
            end
            if (bus.cmd_valid && bus.cmd_ready && ngr < 4) begin
                check("alt_order", 2'd0, exp_seq[ngr]);
                ngr++;
            end
            if (ngr >= 4) begin
                bus.cmd_valid = 1'b0;
                bus.host_req  = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.cmd_valid = 1'b0;
        bus.host_req  = 1'b0;
        check("alt_grant_count", ngr, 4);
        check("alt_rvalid_count", n_rv, 2);
        repeat (25) @(negedge clk);

        // Reset at T+8 of a fetch, then a clean fetch after release.
        run_fetch(4'd2, 4'd1, 10'd40, 16'hFFFF, 8);
        repeat (2) begin
            @(negedge clk);
            check("inrst_lb_we", bus.lb_we, 0);
            check("inrst_done", bus.done, 0);
            check("inrst_busy", bus.busy, 0);
        end
        reset_n = 1'b1;
        run_fetch(4'd2, 4'd1, 10'd40, 16'hFFFF, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
